// File: rtl/speed_ramp.sv
// speed_ramp: rate-limited left/right speed setpoint ramp with tick-paced stepping.
// Define SPEED_RAMP_ESTOP_EN to enable the emergency-stop (STOP) deceleration state.
`ifndef CLK_FREQ
`define CLK_FREQ 50000000
`endif
`ifndef PID_SPEED_FREQ
`define PID_SPEED_FREQ 1000
`endif
`ifndef PID_RES
`define PID_RES 16
`endif

module speed_ramp #(
    parameter int clk_freq  = `CLK_FREQ,
    parameter int ramp_freq = `PID_SPEED_FREQ,
    parameter int pid_res   = `PID_RES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic [pid_res-1:0] tgtL_i,
    input  logic [pid_res-1:0] tgtR_i,
    input  logic [pid_res-1:0] acc_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               estop_i,
    output logic [pid_res-1:0] speedL_o,
    output logic [pid_res-1:0] speedR_o,
    output logic               busy_o,
    output logic               done_o
);
    localparam int n  = clk_freq / ramp_freq;
    localparam int cw = n > 1 ? $clog2(n) : 1;
    localparam logic [cw-1:0] last = cw'(n - 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RAMP = 2'd1;
    localparam logic [1:0] STOP = 2'd2;

    logic [1:0] state;
    logic [cw-1:0] cnt;
    logic signed [pid_res-1:0] cur_l, cur_r, tgt_l, tgt_r, nl, nr;
    logic [pid_res-1:0] acc;
    logic tick, accept;

    // Steps cur toward tgt by at most step; the result always lies between cur and tgt,
    // so modular pid_res-bit arithmetic is exact. step == 0 jumps straight to tgt.
    function automatic logic signed [pid_res-1:0] step_to(
        input logic signed [pid_res-1:0] cur,
        input logic signed [pid_res-1:0] tgt,
        input logic [pid_res+1:0] step
    );
        logic signed [pid_res:0] diff;
        logic [pid_res:0] mag;
        logic signed [pid_res-1:0] sum;
        diff = {tgt[pid_res-1], tgt} - {cur[pid_res-1], cur};
        mag = diff[pid_res] ? -diff : diff;
        sum = diff[pid_res] ? cur - step[pid_res-1:0] : cur + step[pid_res-1:0];
        return (step == '0 || {1'b0, mag} <= step) ? tgt : sum;
    endfunction

    assign tick     = en && cnt == last;
    assign ready_o  = state != STOP;
    assign busy_o   = state != IDLE;
    assign accept   = valid_i && ready_o;
    assign speedL_o = cur_l;
    assign speedR_o = cur_r;
    assign nl = step_to(cur_l, tgt_l, {2'b00, acc});
    assign nr = step_to(cur_r, tgt_r, {2'b00, acc});

`ifdef SPEED_RAMP_ESTOP_EN
    localparam logic [pid_res+1:0] cap = {3'b001, {(pid_res-1){1'b0}}};
    logic [pid_res+1:0] stop_step;
    logic signed [pid_res-1:0] sl, sr;
    assign stop_step = {acc, 2'b00} > cap ? cap : {acc, 2'b00};
    assign sl = step_to(cur_l, '0, stop_step);
    assign sr = step_to(cur_r, '0, stop_step);
`else
    logic unused_estop;
    assign unused_estop = estop_i;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            cur_l <= '0;
            cur_r <= '0;
            tgt_l <= '0;
            tgt_r <= '0;
            acc   <= '0;
            done_o <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            cnt   <= tick ? '0 : cnt + cw'(1);
            cur_l <= '0;
            cur_r <= '0;
            tgt_l <= '0;
            tgt_r <= '0;
            done_o <= 1'b0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + cw'(1);
            done_o <= 1'b0;
`ifdef SPEED_RAMP_ESTOP_EN
            if (estop_i || state == STOP) begin
                if (tick) begin
                    cur_l <= sl;
                    cur_r <= sr;
                end
                if (!estop_i && cur_l == '0 && cur_r == '0) begin
                    state <= IDLE;
                    tgt_l <= '0;
                    tgt_r <= '0;
                end else
                    state <= STOP;
            end else
`endif
            begin
                if (accept) begin
                    tgt_l <= tgtL_i;
                    tgt_r <= tgtR_i;
                    acc   <= acc_i;
                    state <= RAMP;
                end
                // A tick updates from the targets latched before any same-cycle offer
                if (tick && state == RAMP) begin
                    cur_l <= nl;
                    cur_r <= nr;
                    if (!accept && nl == tgt_l && nr == tgt_r) begin
                        done_o <= 1'b1;
                        state  <= IDLE;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_speed_ramp.sv
// tb_speed_ramp: directed checks of speed_ramp with N=100 ticks, 16-bit speeds.
module tb_speed_ramp;
    logic clk = 1'b0, rst = 1'b0, clr = 1'b0, en = 1'b1, valid = 1'b0, estop = 1'b0;
    logic [15:0] tgt_l = '0, tgt_r = '0, acc = '0;
    logic signed [15:0] speed_l, speed_r, e;
    logic ready, busy, done;
    int checks = 0, failures = 0, ph = 0;

    speed_ramp #(.clk_freq(1000), .ramp_freq(10), .pid_res(16)) dut (
        .clk(clk), .rst(rst), .clr(clr), .en(en),
        .tgtL_i(tgt_l), .tgtR_i(tgt_r), .acc_i(acc), .valid_i(valid), .ready_o(ready),
        .estop_i(estop), .speedL_o(speed_l), .speedR_o(speed_r), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    // ph mirrors the DUT tick counter; a tick happens on the edge leaving ph == 99
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rst && en) ph = (ph == 99) ? 0 : ph + 1;
    endtask

    task automatic to_tick();
        while (ph != 99) cyc();
        cyc();
    endtask

    task automatic offer(input int l, input int r, input int a);
        tgt_l = 16'(l); tgt_r = 16'(r); acc = 16'(a); valid = 1'b1;
        cyc();
        valid = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) cyc();
        ph = 0;
        checks++; if (speed_l !== 16'sd0 || speed_r !== 16'sd0) begin failures++; $display("FAIL reset_speed got=%0d,%0d exp=0,0", speed_l, speed_r); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b1;
    endtask

    task automatic test_ramp_basic();
        logic signed [15:0] er;
        offer(1000, -500, 100);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        for (int k = 1; k <= 10; k++) begin
            to_tick();
            e = 16'(100 * k);
            er = (k >= 5) ? -16'sd500 : 16'(-100 * k);
            checks++; if (speed_l !== e) begin failures++; $display("FAIL basic_l k=%0d got=%0d exp=%0d", k, speed_l, e); end
            checks++; if (speed_r !== er) begin failures++; $display("FAIL basic_r k=%0d got=%0d exp=%0d", k, speed_r, er); end
            checks++; if (done !== (k == 10)) begin failures++; $display("FAIL basic_done k=%0d got=%b exp=%b", k, done, k == 10); end
        end
        cyc();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_after got=done%b busy%b exp=0,0", done, busy); end
    endtask

    task automatic test_no_overshoot();
        int exp_l [3] = '{100, 200, 250};
        do_clr();
        checks++; if (speed_l !== 16'sd0 || speed_r !== 16'sd0) begin failures++; $display("FAIL clr_zero got=%0d,%0d exp=0,0", speed_l, speed_r); end
        offer(250, 0, 100);
        for (int k = 0; k < 3; k++) begin
            to_tick();
            e = 16'(exp_l[k]);
            checks++; if (speed_l !== e) begin failures++; $display("FAIL overshoot_l k=%0d got=%0d exp=%0d", k, speed_l, e); end
            checks++; if (done !== (k == 2)) begin failures++; $display("FAIL overshoot_done k=%0d got=%b exp=%b", k, done, k == 2); end
        end
    endtask

    task automatic test_retarget();
        do_clr();
        offer(1000, 0, 100);
        repeat (3) to_tick();
        checks++; if (speed_l !== 16'sd300) begin failures++; $display("FAIL retarget_pre got=%0d exp=300", speed_l); end
        offer(0, 0, 100);
        for (int k = 1; k <= 3; k++) begin
            to_tick();
            e = 16'(300 - 100 * k);
            checks++; if (speed_l !== e) begin failures++; $display("FAIL retarget_l k=%0d got=%0d exp=%0d", k, speed_l, e); end
            checks++; if (done !== (k == 3)) begin failures++; $display("FAIL retarget_done k=%0d got=%b exp=%b", k, done, k == 3); end
        end
    endtask

    task automatic test_no_wrap();
        do_clr();
        offer(32767, 0, 0);
        to_tick();
        checks++; if (speed_l !== 16'sd32767 || done !== 1'b1) begin failures++; $display("FAIL wrap_max got=%0d done%b exp=32767 done1", speed_l, done); end
        offer(-32768, 0, 0);
        to_tick();
        checks++; if (speed_l !== -16'sd32768 || done !== 1'b1) begin failures++; $display("FAIL wrap_min got=%0d done%b exp=-32768 done1", speed_l, done); end
        offer(32767, 0, 100);
        to_tick();
        checks++; if (speed_l !== -16'sd32668) begin failures++; $display("FAIL wrap_step got=%0d exp=-32668", speed_l); end
    endtask

    task automatic test_final_tick_offer();
        do_clr();
        offer(200, 0, 100);
        to_tick();
        while (ph != 99) cyc();
        tgt_l = 16'd500; valid = 1'b1;
        cyc();
        valid = 1'b0;
        checks++; if (speed_l !== 16'sd200 || done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL final_offer got=%0d done%b busy%b exp=200 done0 busy1", speed_l, done, busy); end
        for (int k = 1; k <= 3; k++) begin
            to_tick();
            e = 16'(200 + 100 * k);
            checks++; if (speed_l !== e || done !== (k == 3)) begin failures++; $display("FAIL final_ramp k=%0d got=%0d done%b exp=%0d", k, speed_l, done, e); end
        end
    endtask

    task automatic test_clr_priority();
        do_clr();
        offer(300, 0, 100);
        to_tick();
        while (ph != 99) cyc();
        clr = 1'b1; valid = 1'b1; tgt_l = 16'd900;
        cyc();
        clr = 1'b0; valid = 1'b0;
        checks++; if (speed_l !== 16'sd0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL clr_prio got=%0d busy%b done%b exp=0 busy0 done0", speed_l, busy, done); end
        to_tick();
        checks++; if (speed_l !== 16'sd0 || busy !== 1'b0) begin failures++; $display("FAIL clr_hold got=%0d busy%b exp=0 busy0", speed_l, busy); end
    endtask

    task automatic test_enable();
        do_clr();
        offer(300, 0, 100);
        to_tick();
        en = 1'b0;
        repeat (150) cyc();
        checks++; if (speed_l !== 16'sd100 || busy !== 1'b1) begin failures++; $display("FAIL en_hold got=%0d busy%b exp=100 busy1", speed_l, busy); end
        en = 1'b1;
        to_tick();
        checks++; if (speed_l !== 16'sd200) begin failures++; $display("FAIL en_resume got=%0d exp=200", speed_l); end
    endtask

    task automatic test_estop();
        do_clr();
`ifdef SPEED_RAMP_ESTOP_EN
        offer(800, 0, 100);
        repeat (8) to_tick();
        checks++; if (speed_l !== 16'sd800 || busy !== 1'b0) begin failures++; $display("FAIL estop_pre got=%0d busy%b exp=800 busy0", speed_l, busy); end
        estop = 1'b1;
        cyc();
        checks++; if (ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL estop_enter got=ready%b busy%b exp=ready0 busy1", ready, busy); end
        to_tick();
        checks++; if (speed_l !== 16'sd400) begin failures++; $display("FAIL estop_t1 got=%0d exp=400", speed_l); end
        to_tick();
        cyc();
        checks++; if (speed_l !== 16'sd0 || ready !== 1'b0) begin failures++; $display("FAIL estop_t2 got=%0d ready%b exp=0 ready0", speed_l, ready); end
        estop = 1'b0;
        cyc();
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL estop_exit got=ready%b busy%b done%b exp=1,0,0", ready, busy, done); end
`else
        offer(300, 0, 100);
        estop = 1'b1;
        cyc();
        checks++; if (ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL estop_off got=ready%b busy%b exp=ready1 busy1", ready, busy); end
        to_tick();
        checks++; if (speed_l !== 16'sd100) begin failures++; $display("FAIL estop_off_ramp got=%0d exp=100", speed_l); end
        estop = 1'b0;
`endif
    endtask

    task automatic test_async_reset();
        do_clr();
        offer(1000, -1000, 100);
        repeat (2) to_tick();
        #2;
        rst = 1'b0;
        #1;
        checks++; if (speed_l !== 16'sd0 || speed_r !== 16'sd0) begin failures++; $display("FAIL areset_speed got=%0d,%0d exp=0,0", speed_l, speed_r); end
        checks++; if (busy !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL areset_flags got=busy%b ready%b exp=0,1", busy, ready); end
        repeat (150) cyc();
        checks++; if (speed_l !== 16'sd0 || busy !== 1'b0) begin failures++; $display("FAIL areset_hold got=%0d busy%b exp=0 busy0", speed_l, busy); end
        ph = 0;
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_ramp_basic();
        test_no_overshoot();
        test_retarget();
        test_no_wrap();
        test_final_tick_offer();
        test_clr_priority();
        test_enable();
        test_estop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/speed_ramp.md
SPEED_RAMP -- requirements
Module: speed_ramp

Interface
REQ-001 SHALL have parameter clk_freq, default `CLK_FREQ: system clock frequency in Hz.
REQ-002 SHALL have parameter ramp_freq, default `PID_SPEED_FREQ: ramp update rate in Hz.
REQ-003 SHALL have parameter pid_res, default `PID_RES: speed word width, signed two's complement.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port clr, input, 1 bit: synchronous clear.
REQ-007 SHALL have port en, input, 1 bit: block enable.
REQ-008 SHALL have port tgtL_i, input, pid_res bits: left target speed, signed.
REQ-009 SHALL have port tgtR_i, input, pid_res bits: right target speed, signed.
REQ-010 SHALL have port acc_i, input, pid_res bits: unsigned speed step per tick.
REQ-011 SHALL have port valid_i, input, 1 bit: target/acc offer.
REQ-012 SHALL have port ready_o, output, 1 bit: offer can be accepted.
REQ-013 SHALL have port estop_i, input, 1 bit: emergency stop request.
REQ-014 SHALL have port speedL_o, output, pid_res bits: left setpoint, feeds speedblock speedL_i.
REQ-015 SHALL have port speedR_o, output, pid_res bits: right setpoint, feeds speedblock speedR_i.
REQ-016 SHALL have port busy_o, output, 1 bit: ramp in progress.
REQ-017 SHALL have port done_o, output, 1 bit: one-cycle pulse when both targets are reached.

Function
REQ-018 SHALL generate a one-cycle tick every N = floor(clk_freq/ramp_freq) enabled cycles; the counter runs 0..N-1 and ticks at N-1.
REQ-019 SHALL freeze the tick counter and hold all outputs while en=0.
REQ-020 SHALL implement states IDLE, RAMP and STOP.
REQ-021 SHALL drive ready_o=1 in IDLE and RAMP, and ready_o=0 in STOP.
REQ-022 SHALL, on a cycle with valid_i & ready_o, latch tgtL_i, tgtR_i and acc_i, and enter RAMP on the next cycle.
REQ-023 SHALL apply a new offer accepted in RAMP (retarget) from the next tick, with no restart of the tick phase.
REQ-024 SHALL update each side on every tick in RAMP: diff = tgt - cur, computed in pid_res+1 bits; if |diff| <= acc, then cur = tgt, else cur = cur + sign(diff)*acc.
REQ-025 SHALL treat acc=0 as unlimited: cur = tgt on the next tick.
REQ-026 SHALL NOT wrap; every result lies between cur and tgt inclusive.
REQ-027 SHALL, once both sides equal their targets after a tick, pulse done_o for one cycle and return to IDLE.
REQ-028 SHALL assert busy_o exactly while in RAMP or STOP.
REQ-029 SHALL, on clr=1, zero both speeds and latched targets, go to IDLE with no done_o pulse, and take priority over valid_i and ticks.
REQ-030 SHALL, when valid_i coincides with the final tick, accept the offer, suppress done_o and stay in RAMP.

Reset
REQ-031 SHALL, on rst=0 asynchronously, set speedL_o=0, speedR_o=0, targets=0, acc=0, tick counter=0, done_o=0, busy_o=0, state=IDLE.
REQ-032 SHALL drive ready_o=1 during reset.
REQ-033 SHALL abort a ramp on reset assertion mid-operation, with no further output changes until release.

Configuration
REQ-034 SHALL, with SPEED_RAMP_ESTOP_EN defined, enter STOP from any state when estop_i=1 (below clr, above valid_i).
REQ-035 SHALL, in STOP, move both speeds toward 0 on each tick by min(4*acc, 2^(pid_res-1)), computed without overflow; acc=0 means an immediate stop.
REQ-036 SHALL exit STOP to IDLE, with targets=0 and no done_o pulse, once both speeds are 0 and estop_i=0.
REQ-037 SHALL, without SPEED_RAMP_ESTOP_EN, ignore estop_i, never enter STOP, and keep the port present.

Verification (clk_freq=1000, ramp_freq=10, so N=100, pid_res=16)
REQ-038 SHALL cover: rst low mid-ramp -> speeds 0, busy_o=0, ready_o=1 immediately, without a clock edge.
REQ-039 SHALL cover: tgtL=1000, tgtR=-500, acc=100 -> L steps 100..1000 over 10 ticks, R steps -100..-500 over 5 ticks then holds, done_o pulses once after tick 10.
REQ-040 SHALL cover: tgtL=250, acc=100 -> 100, 200, 250, with no overshoot.
REQ-041 SHALL cover: retarget tgtL=0 at speedL=300 -> 200, 100, 0, then done_o.
REQ-042 SHALL cover: cur=32767, tgt=-32768, acc=0 -> -32768 after one tick, no wrap.
REQ-043 SHALL cover: ESTOP_EN with speedL=800, acc=100, estop_i=1 -> 400, 0, ready_o=0 until estop_i falls; with the macro off -> estop_i has no effect.
